// File: rtl/qmath_pkg.sv
// Shared sign-magnitude Q-format helpers for the streaming arithmetic blocks.
// Holds default format widths, field constants and the pipeline stage record.
package qmath_pkg;

    // Default format: Q15 fractional bits in a 32-bit sign-magnitude word.
    localparam int N_DEF     = 32;
    localparam int Q_DEF     = 15;
    localparam int CNT_W_DEF = 16;

    // Field helpers for the default word width.
    localparam int SIGN_BIT              = N_DEF - 1;
    localparam logic [N_DEF-2:0] MAG_MAX = '1;

    // Magnitude fields are sized for the widest supported word (N <= 64).
    // Narrower words occupy the low N-1 bits and the rest stays zero.
    localparam int MAG_WMAX = 63;

    // One pipeline stage.
    // S1 uses mag_a/mag_b as operand magnitudes, sign as the cleaned
    // sign of a, same/ge as the precomputed path selectors.
    // S2 uses mag_a as the result magnitude, sign as result sign, ovf.
    typedef struct packed {
        logic                valid;
        logic [MAG_WMAX-1:0] mag_a;
        logic [MAG_WMAX-1:0] mag_b;
        logic                sign;
        logic                same;
        logic                ge;
        logic                ovf;
    } stage_t;

endpackage

// File: rtl/qsub_core.sv
// Combinational sign-magnitude add/subtract with saturation.
// Ports:
//   i_mag_a, i_mag_b : operand magnitudes (N-1 bits)
//   i_sign_a         : sign of a (zero magnitude already cleared)
//   i_sign_b         : sign of b as it is to be added (already negated
//                      for a subtract)
//   i_same           : i_sign_a == i_sign_b
//   i_ge             : i_mag_a >= i_mag_b
//   o_mag, o_sign    : result magnitude and sign (zero is always +0)
//   o_ovf            : result magnitude was clamped to all-ones
module qsub_core
    import qmath_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-2:0] i_mag_a,
    input  logic [N-2:0] i_mag_b,
    input  logic         i_sign_a,
    input  logic         i_sign_b,
    input  logic         i_same,
    input  logic         i_ge,
    output logic [N-2:0] o_mag,
    output logic         o_sign,
    output logic         o_ovf
);

    // One extra bit catches the carry out of the magnitude field.
    logic [N-1:0] w_sum;
    logic [N-2:0] w_mag;
    logic         w_sign;
    logic         w_ovf;

    assign w_sum = {1'b0, i_mag_a} + {1'b0, i_mag_b};

    always_comb begin
        w_mag  = '0;
        w_sign = 1'b0;
        w_ovf  = 1'b0;
        if (i_same) begin
            // Like signs: magnitudes add and may overflow.
            w_sign = i_sign_a;
            if (w_sum[N-1]) begin
                w_mag = '1;
                w_ovf = 1'b1;
            end else begin
                w_mag = w_sum[N-2:0];
            end
        end else if (i_ge) begin
            // Unlike signs: the larger magnitude sets the sign,
            // and the difference can never overflow.
            w_mag  = i_mag_a - i_mag_b;
            w_sign = i_sign_a;
        end else begin
            w_mag  = i_mag_b - i_mag_a;
            w_sign = i_sign_b;
        end
    end

    assign o_mag  = w_mag;
    assign o_sign = w_sign & (|w_mag);
    assign o_ovf  = w_ovf;

endmodule

// File: rtl/qsub_axis.sv
// Two-stage streaming sign-magnitude subtractor c = a - b with saturation,
// negative-zero normalisation and a saturating overflow event counter.
// Ports:
//   aclk, areset       : clock, asynchronous active-high reset
//   s_valid/s_ready    : operand handshake, s_a minuend, s_b subtrahend
//   m_valid/m_ready    : result handshake, m_c result, m_ovf saturated flag
//   ovf_count, ovf_clr : accepted-saturation counter and its sync clear
module qsub_axis
    import qmath_pkg::*;
#(
    parameter int Q     = Q_DEF,
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N-1:0]     s_a,
    input  logic [N-1:0]     s_b,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N-1:0]     m_c,
    output logic             m_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_t r_s1;
    stage_t r_s2;
    stage_t w_s1_d;
    stage_t w_s2_d;

    logic             w_adv;
    logic [N-2:0]     w_ma;
    logic [N-2:0]     w_mb;
    logic             w_sa;
    logic             w_sbn;
    logic             w_sign_b1;
    logic [N-2:0]     w_core_mag;
    logic             w_core_sign;
    logic             w_core_ovf;
    logic             w_out_fire;
    logic [CNT_W-1:0] r_cnt;

    // Whole pipeline moves as one; a stalled output freezes both stages.
    assign w_adv   = !r_s2.valid | m_ready;
    assign s_ready = w_adv;

    // Operand cleanup: -0 becomes +0 and b is negated for the subtract.
    assign w_ma  = s_a[N-2:0];
    assign w_mb  = s_b[N-2:0];
    assign w_sa  = s_a[N-1] & (|w_ma);
    assign w_sbn = ~s_b[N-1] & (|w_mb);

    always_comb begin
        w_s1_d       = '0;
        w_s1_d.valid = s_valid;
        w_s1_d.mag_a = MAG_WMAX'(w_ma);
        w_s1_d.mag_b = MAG_WMAX'(w_mb);
        w_s1_d.sign  = w_sa;
        w_s1_d.same  = (w_sa == w_sbn);
        w_s1_d.ge    = (w_ma >= w_mb);
        w_s1_d.ovf   = 1'b0;
    end

    // The negated sign of b is not stored: it equals sa when the signs
    // match and ~sa otherwise (a zero b already forced it to 0, which
    // then implies sa=1 on the unlike path).
    assign w_sign_b1 = r_s1.same ? r_s1.sign : ~r_s1.sign;

    qsub_core #(
        .N (N)
    ) u_core (
        .i_mag_a  (r_s1.mag_a[N-2:0]),
        .i_mag_b  (r_s1.mag_b[N-2:0]),
        .i_sign_a (r_s1.sign),
        .i_sign_b (w_sign_b1),
        .i_same   (r_s1.same),
        .i_ge     (r_s1.ge),
        .o_mag    (w_core_mag),
        .o_sign   (w_core_sign),
        .o_ovf    (w_core_ovf)
    );

    always_comb begin
        w_s2_d       = '0;
        w_s2_d.valid = r_s1.valid;
        w_s2_d.mag_a = MAG_WMAX'(w_core_mag);
        w_s2_d.sign  = w_core_sign;
        w_s2_d.ovf   = w_core_ovf;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else if (w_adv) begin
            r_s1 <= w_s1_d;
            r_s2 <= w_s2_d;
        end
    end

    assign m_valid = r_s2.valid;
    assign m_c     = {r_s2.sign, r_s2.mag_a[N-2:0]};
    assign m_ovf   = r_s2.ovf;

    // Count only saturated results that are actually handed downstream.
    assign w_out_fire = r_s2.valid & m_ready & r_s2.ovf;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_cnt <= '0;
        end else if (ovf_clr) begin
            r_cnt <= '0;
        end else if (w_out_fire && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign ovf_count = r_cnt;

    // Stage fields not consumed in a given stage, and the informational
    // Q parameter, are gathered here so they are visibly intentional.
    logic w_unused;
    assign w_unused = ^{r_s1, r_s2, Q};

endmodule

// File: tb/tb_qsub_axis.sv
// Self-checking bench for qsub_axis: vector table, hand-written
// backpressure/clear/reset sequences and a randomized scoreboard.
module tb_qsub_axis;
    import qmath_pkg::*;

    localparam int N     = 32;
    localparam int CNT_W = 16;

    logic             aclk = 1'b0;
    logic             areset;
    logic             s_valid;
    logic             s_ready;
    logic [N-1:0]     s_a;
    logic [N-1:0]     s_b;
    logic             m_valid;
    logic             m_ready;
    logic [N-1:0]     m_c;
    logic             m_ovf;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clr;

    qsub_axis #(
        .Q     (15),
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a       (s_a),
        .s_b       (s_b),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_c       (m_c),
        .m_ovf     (m_ovf),
        .ovf_count (ovf_count),
        .ovf_clr   (ovf_clr)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        o;
        string       nm;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: real signed arithmetic on the decoded values, then clamp.
    task automatic ref_sub(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] c, output logic o);
        longint va, vb, d, mx;
        mx = longint'(MAG_MAX);
        va = longint'(a[SIGN_BIT-1:0]);
        vb = longint'(b[SIGN_BIT-1:0]);
        if (a[SIGN_BIT]) va = -va;
        if (b[SIGN_BIT]) vb = -vb;
        d = va - vb;
        o = (d > mx) || (d < -mx);
        if (d > mx) d = mx;
        if (d < -mx) d = -mx;
        if (d < 0) c = {1'b1, 31'(-d)};
        else c = {1'b0, 31'(d)};
    endtask

    function automatic logic [31:0] rnd();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return {s, 31'($urandom_range(0, 65535))};
            2: return {s, 31'h0};
            default: return {s, 31'h7FFFFFFF - 31'($urandom_range(0, 3))};
        endcase
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Sends one pair into an empty pipeline and checks 2-cycle latency.
    // clr raises ovf_clr in the cycle the result is handed over.
    task automatic send_check(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] ec, input logic eo,
                              input logic clr, input string nm);
        s_a = a;
        s_b = b;
        s_valid = 1'b1;
        m_ready = 1'b1;
        ovf_clr = 1'b0;
        #1;
        chk({nm, "_rdy"}, 64'(s_ready), 64'(1));
        step();
        s_valid = 1'b0;
        chk({nm, "_lat1"}, 64'(m_valid), 64'(0));
        step();
        chk({nm, "_valid"}, 64'(m_valid), 64'(1));
        chk({nm, "_c"}, 64'(m_c), 64'(ec));
        chk({nm, "_ovf"}, 64'(m_ovf), 64'(eo));
        ovf_clr = clr;
        step();
        ovf_clr = 1'b0;
    endtask

    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    logic [31:0] bp_c[4];
    logic        bp_o[4];
    logic [31:0] q_c[$];
    logic        q_o[$];

    initial begin
        vt[0]  = '{32'h0000C000, 32'h00004000, 32'h00008000, 1'b0, "pos_sub"};
        vt[1]  = '{32'h00004000, 32'h0000C000, 32'h80008000, 1'b0, "neg_res"};
        vt[2]  = '{32'h80008000, 32'h80008000, 32'h00000000, 1'b0, "eq_neg"};
        vt[3]  = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0, "two_zero"};
        vt[4]  = '{32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFF, 1'b1, "sat_pos"};
        vt[5]  = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b1, "sat_neg"};
        vt[6]  = '{32'h40000000, 32'hC0000000, 32'h7FFFFFFF, 1'b1, "edge_sum"};
        vt[7]  = '{32'h3FFFFFFF, 32'hC0000000, 32'h7FFFFFFF, 1'b0, "max_nosat"};
        vt[8]  = '{32'h8000C000, 32'h00004000, 32'h80010000, 1'b0, "neg_m_pos"};
        vt[9]  = '{32'h00001234, 32'h80000000, 32'h00001234, 1'b0, "m_negzero"};
        vt[10] = '{32'h00004000, 32'h80004000, 32'h00008000, 1'b0, "pos_m_neg"};
        vt[11] = '{32'h80004000, 32'h8000C000, 32'h00008000, 1'b0, "neg_m_neg"};
        vt[12] = '{32'h00000000, 32'h00000001, 32'h80000001, 1'b0, "zero_m_pos"};
        vt[13] = '{32'h00000005, 32'h00000005, 32'h00000000, 1'b0, "self_zero"};

        // Reset state
        areset = 1'b1;
        s_valid = 1'b0;
        s_a = '0;
        s_b = '0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        step();
        step();
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_c", 64'(m_c), 64'(0));
        chk("rst_m_ovf", 64'(m_ovf), 64'(0));
        chk("rst_cnt", 64'(ovf_count), 64'(0));
        areset = 1'b0;
        step();
        chk("rel_s_ready", 64'(s_ready), 64'(1));

        // Vector table
        for (int i = 0; i < 14; i++) begin
            send_check(vt[i].a, vt[i].b, vt[i].c, vt[i].o, 1'b0, vt[i].nm);
            if (vt[i].o) exp_cnt++;
            chk({vt[i].nm, "_cnt"}, 64'(ovf_count), 64'(exp_cnt));
        end

        // Clear, single count, then clear colliding with an increment
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        exp_cnt = 0;
        chk("clr_cnt", 64'(ovf_count), 64'(0));
        send_check(32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFF, 1'b1, 1'b0,
                   "ovf_one");
        chk("ovf_one_cnt", 64'(ovf_count), 64'(1));
        send_check(32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFF, 1'b1, 1'b1,
                   "ovf_clr");
        chk("ovf_clr_cnt", 64'(ovf_count), 64'(0));

        // Backpressure: 4 pairs, m_ready low, then released
        begin
            int idx;
            int got;
            logic acc;
            bp_a = '{32'h00010000, 32'h80002000, 32'h7FFFFFFF, 32'h00000003};
            bp_b = '{32'h00008000, 32'h00001000, 32'h80000010, 32'h00000007};
            for (int i = 0; i < 4; i++) ref_sub(bp_a[i], bp_b[i], bp_c[i], bp_o[i]);
            idx = 0;
            m_ready = 1'b0;
            for (int cyc = 0; cyc < 4; cyc++) begin
                s_valid = (idx < 4);
                s_a = bp_a[idx];
                s_b = bp_b[idx];
                #1;
                acc = s_valid && s_ready;
                if (cyc >= 2) begin
                    chk("bp_stall_rdy", 64'(s_ready), 64'(0));
                    chk("bp_stall_vld", 64'(m_valid), 64'(1));
                    chk("bp_stall_c", 64'(m_c), 64'(bp_c[0]));
                end
                step();
                if (acc) idx++;
            end
            chk("bp_accepts", 64'(idx), 64'(2));
            m_ready = 1'b1;
            got = 0;
            for (int cyc = 0; cyc < 8; cyc++) begin
                s_valid = (idx < 4);
                s_a = bp_a[idx & 3];
                s_b = bp_b[idx & 3];
                #1;
                acc = s_valid && s_ready;
                if (m_valid && got < 4) begin
                    chk("bp_order_c", 64'(m_c), 64'(bp_c[got]));
                    chk("bp_order_ovf", 64'(m_ovf), 64'(bp_o[got]));
                    chk("bp_consec", 64'(cyc), 64'(got));
                    got++;
                end
                step();
                if (acc) idx++;
            end
            s_valid = 1'b0;
            chk("bp_results", 64'(got), 64'(4));
            exp_cnt = 0;
            for (int i = 0; i < 4; i++) if (bp_o[i]) exp_cnt++;
            chk("bp_cnt", 64'(ovf_count), 64'(exp_cnt));
        end

        // Randomized stream against the reference model
        begin
            logic took;
            logic [31:0] ec;
            logic eo;
            logic hs_o;
            took = 1'b0;
            for (int it = 0; it < 404; it++) begin
                if (!s_valid || took) begin
                    s_valid = it < 400 && $urandom_range(0, 9) < 7;
                    s_a = rnd();
                    s_b = rnd();
                end
                m_ready = (it >= 400) || ($urandom_range(0, 3) != 0);
                ovf_clr = (it < 400) && ($urandom_range(0, 49) == 0);
                #1;
                took = s_valid && s_ready;
                if (took) begin
                    ref_sub(s_a, s_b, ec, eo);
                    q_c.push_back(ec);
                    q_o.push_back(eo);
                end
                hs_o = 1'b0;
                if (m_valid && m_ready) begin
                    if (q_c.size() == 0) begin
                        chk("rnd_extra", 64'(1), 64'(0));
                    end else begin
                        ec = q_c.pop_front();
                        eo = q_o.pop_front();
                        chk("rnd_c", 64'(m_c), 64'(ec));
                        chk("rnd_ovf", 64'(m_ovf), 64'(eo));
                        hs_o = eo;
                    end
                end
                if (ovf_clr) exp_cnt = 0;
                else if (hs_o && exp_cnt < 65535) exp_cnt++;
                step();
                chk("rnd_cnt", 64'(ovf_count), 64'(exp_cnt));
            end
            s_valid = 1'b0;
            ovf_clr = 1'b0;
            chk("rnd_drained", 64'(q_c.size()), 64'(0));
        end

        // Reset in the middle of a full pipeline
        send_check(32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFF, 1'b1, 1'b0,
                   "pre_rst");
        chk("pre_rst_cnt_nz", 64'(ovf_count != 0), 64'(1));
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_a = 32'h00020000;
        s_b = 32'h00001000;
        step();
        step();
        chk("full_before_rst", 64'(m_valid), 64'(1));
        #2;
        areset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(m_valid), 64'(0));
        chk("mid_rst_cnt", 64'(ovf_count), 64'(0));
        chk("mid_rst_c", 64'(m_c), 64'(0));
        s_valid = 1'b0;
        step();
        #2;
        areset = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_stale", 64'(m_valid), 64'(0));
        end
        send_check(vt[0].a, vt[0].b, vt[0].c, vt[0].o, 1'b0, "post_rst");
        chk("post_rst_cnt", 64'(ovf_count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
